uart_rx_ctrl: RTL

Receive-side sequencer for the UART serial-in/parallel-out datapath. It detects the start bit on an oversampled rx line and counts ticks and bits. It drives the SIPO shift/hold control, checks the stop bit, and presents the captured word through a valid/ready handshake with framing and overrun status. It sits between the baud generator's oversample tick and the SIPO shift register / host-side consumer.

---
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit detection, mid-bit sampling, SIPO shift control,
// stop-bit check and a valid/ready word interface with sticky framing/overrun status.
module uart_rx_ctrl #(
   parameter int WIDTH      = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic             rx,
   input  logic             rx_ready,
   output logic             sipo_bit,
   output logic             sipo_hold,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_error,
   output logic             overrun,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t           state_q;
   logic [TW-1:0]    tick_q;
   logic [BW-1:0]    bit_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [WIDTH-1:0] shift_q;
   logic             strobe_q;
   logic             sipo_bit_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;
   logic             frame_error_q;
   logic             overrun_q;

   // Handshake: a word transfers on any clk where rx_valid & rx_ready are both high;
   // rx_valid drops on the next clk unless a new word loads on that same clk (load wins).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         tick_q        <= '0;
         bit_q         <= '0;
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         shift_q       <= '0;
         strobe_q      <= 1'b0;
         sipo_bit_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         strobe_q  <= 1'b0;
         if (rx_valid_q && rx_ready)
            rx_valid_q <= 1'b0;

         if (sample_tick) begin
            case (state_q)
               IDLE: begin
                  if (!rx_s_q) begin
                     state_q <= START;
                     tick_q  <= '0;
                  end
               end
               START: begin
                  if (tick_q == TICK_MID) begin
                     if (rx_s_q) begin
                        state_q <= IDLE;
                     end else begin
                        state_q <= DATA;
                        tick_q  <= '0;
                        bit_q   <= '0;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_q == TICK_LAST) begin
                     sipo_bit_q <= rx_s_q;
                     shift_q    <= {rx_s_q, shift_q[WIDTH-1:1]};
                     strobe_q   <= 1'b1;
                     tick_q     <= '0;
                     bit_q      <= bit_q + 1'b1;
                     if (bit_q == BIT_LAST)
                        state_q <= STOP;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               STOP: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (rx_s_q) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rx_ready)
                           overrun_q <= 1'b1;
                        state_q <= IDLE;
                     end else begin
                        frame_error_q <= 1'b1;
                        state_q       <= BRK;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               BRK: begin
                  if (rx_s_q)
                     state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign sipo_bit    = sipo_bit_q;
   assign sipo_hold   = ~strobe_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state   = state_q;

endmodule
